// File: rtl/sipo_framer_ble_if.sv
// Output word handshake bundle for the BLE SIPO framer.
// Master drives the held word; slave returns out_ready.
interface sipo_framer_ble_if #(
  parameter int DATA = 32
);
  localparam int CW = $clog2(DATA + 1);

  logic [DATA-1:0] data_out;
  logic [CW-1:0]   out_bits;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output data_out,
    output out_bits,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_bits,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_framer_ble.sv
// BLE PHY serial-to-parallel framer with one-deep output register,
// partial-word flush, assembly clear and sticky overflow.
module sipo_framer_ble #(
  parameter  int DATA = 32,
  localparam int CW   = $clog2(DATA + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  input  logic              we,
  input  logic              lsb_first,
  input  logic              flush,
  input  logic              clr,
  input  logic              ovf_clr,
  sipo_framer_ble_if.master bus,
  output logic              done,
  output logic              ovf,
  output logic [CW-1:0]     bit_cnt
);

  logic [DATA-1:0] asm_q;
  logic [DATA-1:0] asm_nxt;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   pos;
  logic            ord_q;
  logic            ord;
  logic            full;
  logic            prod;
  logic            accept;
  logic            load;
  logic            drop;

  logic [DATA-1:0] dout_q;
  logic [CW-1:0]   obits_q;
  logic            ovalid_q;
  logic            done_q;
  logic            ovf_q;

  // Next assembly word and word-production decision.
  always_comb begin
    ord = ord_q;
    if (cnt_q == '0)
      ord = lsb_first;
    pos = ord ? cnt_q : (CW'(DATA - 1) - cnt_q);
    asm_nxt = asm_q;
    for (int i = 0; i < DATA; i++) begin
      if (we && (CW'(i) == pos))
        asm_nxt[i] = data_in;
    end
    cnt_nxt = cnt_q + CW'(we);
    full    = we && (cnt_q == CW'(DATA - 1));
    prod    = !clr &&
              (full || (flush && (cnt_nxt != '0)));
    accept  = ovalid_q && bus.out_ready;
    load    = prod && (!ovalid_q || accept);
    drop    = prod && !load;
  end

  // Assembly register, bit counter and latched bit order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q <= '0;
      cnt_q <= '0;
      ord_q <= 1'b0;
    end else begin
      ord_q <= ord;
      if (clr || prod) begin
        asm_q <= '0;
        cnt_q <= '0;
      end else begin
        asm_q <= asm_nxt;
        cnt_q <= cnt_nxt;
      end
    end
  end

  // Output holding register, done pulse and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q   <= '0;
      obits_q  <= '0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= load;
      if (load) begin
        dout_q   <= asm_nxt;
        obits_q  <= cnt_nxt;
        ovalid_q <= 1'b1;
      end else if (accept) begin
        ovalid_q <= 1'b0;
      end
      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.out_bits  = obits_q;
  assign bus.out_valid = ovalid_q;
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign bit_cnt       = cnt_q;

endmodule

// File: tb/tb_sipo_framer_ble.sv
// Bench for sipo_framer_ble (DATA=8): vector table, corner
// sequences and random traffic against a queue-based model.
module tb_sipo_framer_ble;
  localparam int DATA = 8;
  localparam int CW   = $clog2(DATA + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic we = 1'b0;
  logic lsb_first = 1'b1;
  logic flush = 1'b0;
  logic clr = 1'b0;
  logic ovf_clr = 1'b0;
  logic done;
  logic ovf;
  logic [CW-1:0] bit_cnt;

  sipo_framer_ble_if #(.DATA(DATA)) bus ();

  sipo_framer_ble #(.DATA(DATA)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .we        (we),
    .lsb_first (lsb_first),
    .flush     (flush),
    .clr       (clr),
    .ovf_clr   (ovf_clr),
    .bus       (bus.master),
    .done      (done),
    .ovf       (ovf),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit            q[$];
  bit            m_ord;
  logic [DATA-1:0] m_data;
  int            m_bits;
  bit            m_valid;
  bit            m_done;
  bit            m_ovf;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ord   = 1'b0;
    m_data  = '0;
    m_bits  = 0;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit i_we, i_d, i_lsb,
                            i_fl, i_clr, i_oc, i_rdy);
    bit acc, prod, load;
    logic [DATA-1:0] w;
    int pb;
    acc  = m_valid && i_rdy;
    prod = 1'b0;
    w    = '0;
    pb   = 0;
    if (i_clr) begin
      q.delete();
    end else begin
      if (i_we) begin
        if (q.size() == 0) m_ord = i_lsb;
        q.push_back(i_d);
      end
      if (q.size() == DATA ||
          (i_fl && q.size() > 0)) begin
        prod = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
          if (m_ord) w[k] = q[k];
          else       w[DATA-1-k] = q[k];
        end
        pb = q.size();
        q.delete();
      end
    end
    load   = prod && (!m_valid || acc);
    m_done = load;
    if (load) begin
      m_valid = 1'b1;
      m_data  = w;
      m_bits  = pb;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    if (prod && !load) m_ovf = 1'b1;
    else if (i_oc)     m_ovf = 1'b0;
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.data_out, bus.out_bits,
                bus.out_valid, done, ovf, bit_cnt});
  endfunction

  function automatic logic [63:0] mdl_vec();
    logic [CW-1:0] b, c;
    b = CW'(m_bits);
    c = CW'(q.size());
    return 64'({m_data, b, m_valid, m_done, m_ovf, c});
  endfunction

  task automatic step(input bit i_we, i_d, i_lsb,
                      input bit i_fl, i_clr, i_oc, i_rdy);
    we            = i_we;
    data_in       = i_d;
    lsb_first     = i_lsb;
    flush         = i_fl;
    clr           = i_clr;
    ovf_clr       = i_oc;
    bus.out_ready = i_rdy;
    @(posedge clk);
    model_step(i_we, i_d, i_lsb, i_fl, i_clr, i_oc, i_rdy);
    #1;
    chk("state", dut_vec(), mdl_vec());
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask

  // lsb_first is inverted after the first bit to show it is latched
  task automatic send(input logic [7:0] bits, input int n,
                      input bit lsb, input bit fl_last,
                      input bit rdy, input bit oc_last);
    for (int i = 0; i < n; i++) begin
      step(1, bits[i], (i == 0) ? lsb : !lsb,
           fl_last && (i == n - 1), 0,
           oc_last && (i == n - 1), rdy);
    end
  endtask

  typedef struct {
    logic [7:0] bits;
    int         n;
    bit         lsb;
    bit         fl;
    logic [7:0] exp_d;
    int         exp_b;
  } vec_t;

  vec_t vt[6];

  initial begin
    bus.out_ready = 1'b0;
    model_reset();

    vt[0] = '{8'h8D, 8, 1'b1, 1'b0, 8'h8D, 8};
    vt[1] = '{8'h8D, 8, 1'b0, 1'b0, 8'hB1, 8};
    vt[2] = '{8'h03, 3, 1'b1, 1'b1, 8'h03, 3};
    vt[3] = '{8'h03, 3, 1'b0, 1'b1, 8'hC0, 3};
    vt[4] = '{8'h05, 5, 1'b0, 1'b1, 8'hA0, 5};
    vt[5] = '{8'hFF, 1, 1'b1, 1'b1, 8'h01, 1};

    @(posedge clk);
    #1;
    chk("reset", dut_vec(), 64'd0);
    reset = 1'b0;

    // table vectors, consumer always ready
    for (int v = 0; v < 6; v++) begin
      send(vt[v].bits, vt[v].n, vt[v].lsb,
           vt[v].fl, 1, 0);
      chk("vec data", 64'(bus.data_out), 64'(vt[v].exp_d));
      chk("vec bits", 64'(bus.out_bits), 64'(vt[v].exp_b));
      chk("vec done", 64'({bus.out_valid, done}), 64'd3);
      idle(1);
    end
    chk("drained", 64'(bus.out_valid), 64'd0);

    // flush with empty assembly produces nothing
    step(0, 0, 1, 1, 0, 0, 1);
    chk("empty flush", 64'({bus.out_valid, done}), 64'd0);

    // overflow: first held, second dropped
    send(8'h8D, 8, 1, 0, 0, 0);
    send(8'h3C, 8, 1, 0, 0, 0);
    chk("ovf set", 64'(ovf), 64'd1);
    chk("held word", 64'(bus.data_out), 64'h8D);
    send(8'h77, 8, 1, 0, 0, 1);
    chk("ovf set wins", 64'(ovf), 64'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ovf cleared", 64'(ovf), 64'd0);

    // back-to-back load when accepted on completion cycle
    send(8'hE4, 7, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    chk("b2b data", 64'(bus.data_out), 64'hE4);
    chk("b2b flags",
        64'({bus.out_valid, done, ovf}), 64'b110);
    idle(0);
    chk("done one cycle", 64'(done), 64'd0);
    idle(1);

    // clr discards a partial word and a same-cycle bit
    send(8'h1F, 5, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0, 1);
    chk("clr cnt", 64'(bit_cnt), 64'd0);
    chk("clr noword", 64'({bus.out_valid, done}), 64'd0);

    // asynchronous reset with a word held
    send(8'hA5, 8, 1, 0, 0, 0);
    send(8'h0F, 3, 1, 0, 0, 0);
    chk("pre reset", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async reset", dut_vec(), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0,
           1'($urandom),
           1'($urandom),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
